// File: rtl/majority_vote_ctrl.sv
// majority_vote_ctrl: five-voter ballot collector with timeout and 3-of-5 decision.
// Optional macro EARLY_DECIDE_EN closes a ballot as soon as 3 equal votes are in.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle pulse opening a ballot (IDLE only)
//   vote_valid, vote_val  per-voter strobe and value (bit i = voter i)
//   vote_ack              one-cycle pulse per accepted vote
//   busy                  high whenever the FSM is not in IDLE
//   voted                 mask of accepted voters in current/last ballot
//   result, result_valid  majority of last ballot and its update pulse
//   timed_out             last ballot closed on timeout without 5 votes
module majority_vote_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] vote_valid,
  input  logic [4:0] vote_val,
  output logic [4:0] vote_ack,
  output logic       busy,
  output logic [4:0] voted,
  output logic       result,
  output logic       result_valid,
  output logic       timed_out
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DECIDE,
    DONE
  } state_t;

  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] cnt;
  logic [4:0] votes;

  logic [4:0] acc;
  logic [4:0] nxt_voted;
  logic [4:0] nxt_votes;
  logic       all_in;
  logic       cnt_end;
  logic       early;

  function automatic logic [2:0] pop5(input logic [4:0] v);
    pop5 = 3'(v[0]) + 3'(v[1]) + 3'(v[2])
         + 3'(v[3]) + 3'(v[4]);
  endfunction

  // Votes accepted at this edge, including same-cycle ones.
  always_comb begin
    acc       = vote_valid & ~voted;
    nxt_voted = voted | acc;
    nxt_votes = votes | (acc & vote_val);
    all_in    = &nxt_voted;
    cnt_end   = (cnt == 8'd1);
  end

`ifdef EARLY_DECIDE_EN
  logic [2:0] ones;
  logic [2:0] zeros;

  always_comb begin
    ones  = pop5(nxt_votes);
    zeros = pop5(nxt_voted & ~nxt_votes);
    early = (ones >= 3'd3) || (zeros >= 3'd3);
  end
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      votes        <= '0;
      voted        <= '0;
      vote_ack     <= '0;
      busy         <= 1'b0;
      result       <= 1'b0;
      result_valid <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      vote_ack     <= '0;
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= COLLECT;
            busy      <= 1'b1;
            voted     <= '0;
            votes     <= '0;
            timed_out <= 1'b0;
            cnt       <= TO_LOAD;
          end
        end
        COLLECT: begin
          voted    <= nxt_voted;
          votes    <= nxt_votes;
          vote_ack <= acc;
          cnt      <= cnt - 8'd1;
          if (all_in || early || cnt_end) begin
            state     <= DECIDE;
            // A vote completing 5/5 on the last cycle wins.
            timed_out <= cnt_end && !all_in && !early;
          end
        end
        DECIDE: begin
          // Missing votes were cleared at start, so they count as 0.
          result <= (pop5(votes) >= 3'd3);
          state  <= DONE;
        end
        DONE: begin
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_majority_vote_ctrl.sv
// tb_majority_vote_ctrl: directed self-checking bench for majority_vote_ctrl.
// Define EARLY_DECIDE_EN for both DUT and bench to cover the early exit.
module tb_majority_vote_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [4:0] vote_valid = '0;
  logic [4:0] vote_val = '0;
  logic [4:0] vote_ack;
  logic       busy;
  logic [4:0] voted;
  logic       result;
  logic       result_valid;
  logic       timed_out;

  int checks = 0;
  int errors = 0;

  majority_vote_ctrl #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vote_valid   (vote_valid),
    .vote_val     (vote_val),
    .vote_ack     (vote_ack),
    .busy         (busy),
    .voted        (voted),
    .result       (result),
    .result_valid (result_valid),
    .timed_out    (timed_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rv(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (result_valid !== 1'b1 && n < 40);
  endtask

  task automatic open_ballot();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    #3 rst_n = 1'b0;
    tick();
    tick();
    outs = {busy, vote_ack, voted, result, result_valid, timed_out};
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL reset_outs: got %b want 0", outs);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_all_same_cycle();
    open_ballot();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL same_busy: got %b want 1", busy);
    end
    vote_valid = 5'b11111;
    vote_val   = 5'b10011;
    tick();
    checks++;
    if (vote_ack !== 5'b11111) begin
      errors++;
      $display("FAIL same_ack: got %b want 11111", vote_ack);
    end
    vote_valid = '0;
    tick();
    checks++;
    if (vote_ack !== 5'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_ack_end: ack %b rv %b want 0 0",
               vote_ack, result_valid);
    end
    tick();
    checks++;
    if ({result_valid, result, timed_out, busy} !== 4'b1100) begin
      errors++;
      $display("FAIL same_done: rv/res/to/busy %b want 1100",
               {result_valid, result, timed_out, busy});
    end
    tick();
    checks++;
    if (result_valid !== 1'b0 || result !== 1'b1) begin
      errors++;
      $display("FAIL same_hold: rv %b res %b want 0 1",
               result_valid, result);
    end
  endtask

  task automatic test_timeout();
    int n;
    open_ballot();
    vote_valid = 5'b00011;
    vote_val   = 5'b00011;
    tick();
    checks++;
    if (vote_ack !== 5'b00011) begin
      errors++;
      $display("FAIL to_ack: got %b want 00011", vote_ack);
    end
    vote_valid = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || voted !== 5'b00011) begin
      errors++;
      $display("FAIL to_start_ignored: busy %b voted %b want 1 00011",
               busy, voted);
    end
    wait_rv(n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL to_latency: got %0d want 16", n);
    end
    checks++;
    if ({timed_out, voted, result} !== 7'b1_00011_0) begin
      errors++;
      $display("FAIL to_outs: to/voted/res %b want 1000110",
               {timed_out, voted, result});
    end
  endtask

  task automatic test_repeat_vote();
    int n;
    for (int k = 0; k < 2; k++) begin
      open_ballot();
      vote_valid = 5'b00111;
      vote_val   = 5'b00011;
      tick();
      checks++;
      if (vote_ack !== 5'b00111) begin
        errors++;
        $display("FAIL rep_ack1[%0d]: got %b want 00111", k, vote_ack);
      end
      vote_valid = 5'b11100;
      vote_val   = (k == 0) ? 5'b11100 : 5'b00100;
      tick();
      checks++;
      if (vote_ack !== 5'b11000) begin
        errors++;
        $display("FAIL rep_ack2[%0d]: got %b want 11000", k, vote_ack);
      end
      vote_valid = '0;
      wait_rv(n);
      checks++;
      if (n != 2 || result !== (k == 0) || voted !== 5'b11111) begin
        errors++;
        $display("FAIL rep_res[%0d]: n %0d res %b voted %b want 2 %b 11111",
                 k, n, result, voted, (k == 0));
      end
    end
  endtask

  task automatic test_final_cycle();
    int n;
    logic [4:0] last;
    for (int k = 0; k < 2; k++) begin
      open_ballot();
      vote_valid = (k == 0) ? 5'b01111 : 5'b00111;
      vote_val   = 5'b00011;
      tick();
      vote_valid = '0;
      repeat (14) tick();
      checks++;
      if (busy !== 1'b1 || result_valid !== 1'b0) begin
        errors++;
        $display("FAIL fin_busy[%0d]: busy %b rv %b want 1 0",
                 k, busy, result_valid);
      end
      last       = (k == 0) ? 5'b10000 : 5'b01000;
      vote_valid = last;
      vote_val   = (k == 0) ? 5'b10000 : 5'b00000;
      tick();
      checks++;
      if (vote_ack !== last) begin
        errors++;
        $display("FAIL fin_ack[%0d]: got %b want %b", k, vote_ack, last);
      end
      vote_valid = '0;
      wait_rv(n);
      checks++;
      if (n != 2) begin
        errors++;
        $display("FAIL fin_latency[%0d]: got %0d want 2", k, n);
      end
      checks++;
      if (timed_out !== (k == 1) || result !== (k == 0) ||
          voted !== ((k == 0) ? 5'b11111 : 5'b01111)) begin
        errors++;
        $display("FAIL fin_outs[%0d]: to %b res %b voted %b", k,
                 timed_out, result, voted);
      end
    end
  endtask

  task automatic test_idle_ignore();
    vote_valid = 5'b11111;
    vote_val   = 5'b11111;
    tick();
    tick();
    checks++;
    if ({vote_ack, busy, voted, result, timed_out} !==
        13'b00000_0_01111_0_1) begin
      errors++;
      $display("FAIL idle_hold: ack %b busy %b voted %b res %b to %b",
               vote_ack, busy, voted, result, timed_out);
    end
    vote_valid = '0;
  endtask

  task automatic test_reset_mid();
    int n;
    logic [13:0] outs;
    open_ballot();
    vote_valid = 5'b00001;
    vote_val   = 5'b00001;
    tick();
    vote_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    outs = {busy, vote_ack, voted, result, result_valid, timed_out};
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL rst_async: got %b want 0", outs);
    end
    tick();
    tick();
    outs = {busy, vote_ack, voted, result, result_valid, timed_out};
    checks++;
    if (outs !== 14'd0) begin
      errors++;
      $display("FAIL rst_held: got %b want 0", outs);
    end
    rst_n = 1'b1;
    open_ballot();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_first_start: busy %b want 1", busy);
    end
    vote_valid = 5'b11111;
    vote_val   = 5'b00000;
    tick();
    checks++;
    if (vote_ack !== 5'b11111) begin
      errors++;
      $display("FAIL rst_ack: got %b want 11111", vote_ack);
    end
    vote_valid = '0;
    wait_rv(n);
    checks++;
    if (n != 2 || result !== 1'b0 || timed_out !== 1'b0 ||
        voted !== 5'b11111) begin
      errors++;
      $display("FAIL rst_ballot: n %0d res %b to %b voted %b", n,
               result, timed_out, voted);
    end
  endtask

`ifdef EARLY_DECIDE_EN
  task automatic test_early();
    open_ballot();
    vote_valid = 5'b01011;
    vote_val   = 5'b01011;
    tick();
    checks++;
    if (vote_ack !== 5'b01011) begin
      errors++;
      $display("FAIL early_ack: got %b want 01011", vote_ack);
    end
    vote_valid = 5'b10000;
    vote_val   = 5'b10000;
    tick();
    checks++;
    if (vote_ack !== 5'b00000) begin
      errors++;
      $display("FAIL early_late_ack: got %b want 00000", vote_ack);
    end
    vote_valid = '0;
    tick();
    checks++;
    if ({result_valid, result, timed_out, voted} !== 8'b110_01011) begin
      errors++;
      $display("FAIL early_done: rv/res/to/voted %b want 11001011",
               {result_valid, result, timed_out, voted});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_same_cycle();
    test_timeout();
    test_repeat_vote();
    test_final_cycle();
    test_idle_ignore();
    test_reset_mid();
`ifdef EARLY_DECIDE_EN
    test_early();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
